// File: rtl/cam_capture_ctrl_pkg.sv
// Shared definitions for the camera capture write-side sequencer:
// FSM state type, default frame geometry and the RGB565 -> RGB332 packing rule.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_CAPTURE,
        ST_DONE
    } cam_state_t;

    localparam int unsigned IMG_W_DEF = 160;
    localparam int unsigned IMG_H_DEF = 120;

    // Number of pixels stored per frame.
    function automatic int unsigned calc_npix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // b1 = {R[4:0],G[5:3]}, b2 = {G[2:0],B[4:0]}; keep the top bits of each channel.
    function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[7:5], b1[2:0], b2[4:3]};
    endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera pin / frame-buffer write-port bundle for cam_capture_ctrl.
// master: the side driving the camera pins and observing the buffer port.
// slave:  the capture controller itself.
interface cam_capture_ctrl_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 8
) ();
    logic          init;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          frame_done;
    logic          busy;

    modport master (
        output init, vsync, href, px_data,
        input  mem_px_addr, mem_px_data, px_wr, frame_done, busy
    );

    modport slave (
        input  init, vsync, href, px_data,
        output mem_px_addr, mem_px_data, px_wr, frame_done, busy
    );
endinterface

// File: rtl/cam_capture_ctrl_rgb.sv
// Combinational RGB565 byte pair to RGB332 pixel packer.
module rgb565_to_rgb332 (
    input  logic [7:0] b1,
    input  logic [7:0] b2,
    output logic [7:0] px
);
    assign px = cam_pkg::rgb565_to_rgb332(b1, b2);
endmodule

// File: rtl/cam_capture_ctrl.sv
// Write-side sequencer for the dual-port frame buffer: decodes the OV7670
// vsync/href/byte stream, packs byte pairs into RGB332 pixels and writes them
// to a linear address. All outputs are registered.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned AW    = 15,
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    cam_capture_ctrl_if.slave bus
);

    localparam logic [AW-1:0] NPIX = AW'(calc_npix(IMG_W, IMG_H));

    cam_state_t    state;
    logic          vsync_d;
    logic          byte_phase;
    logic [7:0]    byte1;
    logic [AW-1:0] count;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          px_wr_q;
    logic          frame_done_q;
    logic          busy_q;
    logic [7:0]    packed_px;

    rgb565_to_rgb332 u_pack (
        .b1 (byte1),
        .b2 (bus.px_data),
        .px (packed_px)
    );

    // Previous vsync sample, used to detect the falling edge that opens a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= bus.vsync;
        end
    end

    // Capture FSM with byte pairing, address counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            byte_phase   <= 1'b0;
            byte1        <= '0;
            count        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            px_wr_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            px_wr_q      <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    busy_q     <= 1'b0;
                    byte_phase <= 1'b0;
                    if (bus.init) begin
                        state <= ST_WAIT_VS;
                    end
                end
                ST_WAIT_VS: begin
                    byte_phase <= 1'b0;
                    if (!bus.init) begin
                        state <= ST_IDLE;
                    end else if (vsync_d && !bus.vsync) begin
                        state  <= ST_CAPTURE;
                        busy_q <= 1'b1;
                        count  <= '0;
                        addr_q <= '0;
                    end
                end
                ST_CAPTURE: begin
                    // vsync takes priority over a byte presented on the same edge
                    if (bus.vsync) begin
                        state        <= ST_DONE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        byte_phase   <= 1'b0;
                    end else if (bus.href) begin
                        byte_phase <= ~byte_phase;
                        if (!byte_phase) begin
                            byte1 <= bus.px_data;
                        end else if (count != NPIX) begin
                            px_wr_q <= 1'b1;
                            data_q  <= DW'(packed_px);
                            addr_q  <= count;
                            count   <= count + AW'(1);
                        end
                    end else begin
                        // an orphan first byte at end of line is dropped
                        byte_phase <= 1'b0;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= bus.init ? ST_WAIT_VS : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_px_addr = addr_q;
    assign bus.mem_px_data = data_q;
    assign bus.px_wr       = px_wr_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl: random camera byte streams checked
// against an arithmetic reference of the expected pixel writes.
module tb_cam_capture_ctrl;

    localparam int NPIX = 160 * 120;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cam_capture_ctrl_if #(.AW(15), .DW(8)) bus ();

    cam_capture_ctrl #(
        .AW    (15),
        .DW    (8),
        .IMG_W (160),
        .IMG_H (120)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned n_pass   = 0;
    int unsigned n_checks = 0;
    int          pix      = 0;
    bit          capturing = 1'b0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: split into 5/6/5 channels, keep the top 3/3/2 bits of each.
    function automatic logic [7:0] ref_pixel(input logic [7:0] b1, input logic [7:0] b2);
        int r5, g6, b5;
        r5 = int'(b1) >> 3;
        g6 = ((int'(b1) & 7) << 3) | (int'(b2) >> 5);
        b5 = int'(b2) & 31;
        return 8'(((r5 >> 2) << 5) | ((g6 >> 3) << 2) | (b5 >> 3));
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 0: random bytes, 1: 0x07/0xE0 pairs, 2: 0xF8/0x1F pairs
    task automatic send_line(input int nbytes, input int mode);
        logic [7:0] b1, d;
        int gap;
        b1 = '0;
        for (int j = 0; j < nbytes; j++) begin
            if (mode == 1)      d = (j % 2 == 0) ? 8'h07 : 8'hE0;
            else if (mode == 2) d = (j % 2 == 0) ? 8'hF8 : 8'h1F;
            else                d = 8'($urandom);
            bus.href    = 1'b1;
            bus.px_data = d;
            tick();
            if (j % 2 == 0) begin
                b1 = d;
                check("wr_first_byte", bus.px_wr, 0);
            end else begin
                if (capturing && pix < NPIX) begin
                    check("wr_pulse", bus.px_wr, 1);
                    check("wr_addr", bus.mem_px_addr, pix);
                    check("wr_data", bus.mem_px_data, ref_pixel(b1, d));
                end else begin
                    check("wr_suppressed", bus.px_wr, 0);
                end
                pix++;
            end
        end
        bus.href    = 1'b0;
        bus.px_data = 8'($urandom);
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
            tick();
            check("wr_in_gap", bus.px_wr, 0);
        end
    endtask

    task automatic start_frame(input bit exp_busy);
        bus.href  = 1'b0;
        bus.vsync = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wr_in_vsync", bus.px_wr, 0);
        end
        bus.vsync = 1'b0;
        tick();
        check("busy_start", bus.busy, exp_busy);
        capturing = exp_busy;
        pix = 0;
    endtask

    // A first byte is pending when vsync rises with href still high.
    task automatic end_frame(input bit next_init);
        bus.href    = 1'b1;
        bus.px_data = 8'($urandom);
        tick();
        check("wr_pre_vsync", bus.px_wr, 0);
        bus.vsync   = 1'b1;
        bus.px_data = 8'($urandom);
        tick();
        check("frame_done_pulse", bus.frame_done, 1);
        check("wr_vsync_wins", bus.px_wr, 0);
        check("busy_done", bus.busy, 0);
        bus.href = 1'b0;
        bus.init = next_init;
        tick();
        check("frame_done_single", bus.frame_done, 0);
        check("busy_after_done", bus.busy, 0);
        capturing = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"}, bus.px_wr, 0);
        check({tag, "_fd"}, bus.frame_done, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_addr"}, bus.mem_px_addr, 0);
        check({tag, "_data"}, bus.mem_px_data, 0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.init    = 1'b0;
        bus.vsync   = 1'b0;
        bus.href    = 1'b0;
        bus.px_data = '0;
        #2;
        check_all_zero("reset_async");
        repeat (3) tick();
        check_all_zero("reset_held");
        rst = 1'b0;
        tick();
        check_all_zero("reset_release");

        // single pixel 0xF8,0x1F -> 0xE3 at address 0
        bus.init = 1'b1;
        start_frame(1'b1);
        send_line(2, 2);
        end_frame(1'b1);

        // full frame of 0x07/0xE0 plus one extra pixel that must be suppressed
        start_frame(1'b1);
        for (int l = 0; l < 120; l++) send_line(320, 1);
        check("addr_last", bus.mem_px_addr, NPIX - 1);
        send_line(2, 1);
        check("addr_hold", bus.mem_px_addr, NPIX - 1);
        end_frame(1'b1);

        // random lines including odd-length ones; continuous capture
        start_frame(1'b1);
        send_line(3, 0);
        send_line(2, 0);
        for (int l = 0; l < 6; l++) send_line($urandom_range(1, 12), 0);
        end_frame(1'b1);

        // second frame restarts at address 0; init drops mid-frame
        start_frame(1'b1);
        for (int l = 0; l < 3; l++) send_line($urandom_range(2, 10), 0);
        bus.init = 1'b0;
        for (int l = 0; l < 3; l++) send_line($urandom_range(2, 10), 0);
        check("busy_after_init_drop", bus.busy, 1);
        end_frame(1'b0);

        // idle: a vsync falling edge must not start capture
        start_frame(1'b0);
        send_line(6, 0);

        // reset mid-line while a write is on the port
        bus.init = 1'b1;
        start_frame(1'b1);
        send_line(4, 0);
        bus.href    = 1'b1;
        bus.px_data = 8'($urandom);
        tick();
        bus.px_data = 8'($urandom);
        tick();
        check("wr_before_rst", bus.px_wr, 1);
        rst = 1'b1;
        #1;
        check_all_zero("reset_midline");
        for (int k = 0; k < 4; k++) begin
            bus.px_data = 8'($urandom);
            tick();
            check("wr_in_reset", bus.px_wr, 0);
        end
        bus.init = 1'b0;
        rst = 1'b0;
        capturing = 1'b0;
        send_line(6, 0);
        check("busy_after_reset", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
